// File: rtl/udm_bus_arbiter_if.sv
// rtl/udm_bus_arbiter_if.sv - req/ack/resp system-bus port bundle
//
// Purpose: one req/ack/resp bus port, used for both the master-side and
//          the slave-side connections of udm_bus_arbiter.
// Signals:
//    req    request, held by the master until ack
//    we     write enable
//    addr   32-bit address
//    be     4-bit byte enables
//    wdata  32-bit write data
//    ack    request accepted (1-cycle pulse)
//    resp   read data valid (1-cycle pulse)
//    rdata  32-bit read data, valid with resp
// Modports:
//    master  drives req/we/addr/be/wdata, receives ack/resp/rdata
//    slave   receives req/we/addr/be/wdata, drives ack/resp/rdata
interface udm_bus_arbiter_if;
   logic        req;
   logic        we;
   logic [31:0] addr;
   logic [3:0]  be;
   logic [31:0] wdata;
   logic        ack;
   logic        resp;
   logic [31:0] rdata;

   modport master (output req, we, addr, be, wdata, input ack, resp, rdata);
   modport slave  (input req, we, addr, be, wdata, output ack, resp, rdata);
endinterface

// File: rtl/udm_bus_arbiter.sv
// rtl/udm_bus_arbiter.sv - two-master round-robin arbiter onto one system bus
//
// Purpose: shares one req/ack/resp slave port between m0 (udm debug master)
//          and m1 (e.g. CPU data port). One transaction in flight at a time;
//          a read that gets no response within RESP_TIMEOUT cycles is
//          completed with TIMEOUT_RDATA so a dead slave cannot hang a master.
// Ports:
//    clk_i      clock, rising edge
//    rst_i      synchronous active-high reset
//    m0, m1     master-facing ports (slave modport of udm_bus_arbiter_if)
//    bus        system-bus port (master modport of udm_bus_arbiter_if)
//    timeout_o  1-cycle pulse when a read times out
module udm_bus_arbiter #(
   parameter int          RESP_TIMEOUT  = 1024,
   parameter logic [31:0] TIMEOUT_RDATA = 32'hDEADBEEF
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   udm_bus_arbiter_if.slave      m0,
   udm_bus_arbiter_if.slave      m1,
   udm_bus_arbiter_if.master     bus,
   output logic                  timeout_o
);

   localparam int TW = $clog2(RESP_TIMEOUT);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2
   } state_t;

   state_t        r_state;
   logic          r_grant;
   logic          r_last;
   logic [TW-1:0] r_tcnt;

   logic          w_pick;
   logic          w_g_req;
   logic          w_g_we;
   logic [31:0]   w_g_addr;
   logic [3:0]    w_g_be;
   logic [31:0]   w_g_wdata;
   logic          w_in_req;
   logic          w_in_wait;
   logic          w_tmo_hit;
   logic          w_ack;
   logic          w_resp;
   logic          w_timeout;
   logic [31:0]   w_rdata;

   // On a tie the master that did not win last time gets the bus.
   assign w_pick    = (m0.req && m1.req) ? ~r_last : m1.req;

   assign w_g_req   = r_grant ? m1.req   : m0.req;
   assign w_g_we    = r_grant ? m1.we    : m0.we;
   assign w_g_addr  = r_grant ? m1.addr  : m0.addr;
   assign w_g_be    = r_grant ? m1.be    : m0.be;
   assign w_g_wdata = r_grant ? m1.wdata : m0.wdata;

   assign w_in_req  = (r_state == ST_REQ);
   assign w_in_wait = (r_state == ST_WAIT);
   assign w_tmo_hit = (r_tcnt == TW'(RESP_TIMEOUT - 1));

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state <= ST_IDLE;
         r_grant <= 1'b0;
         r_last  <= 1'b1;
         r_tcnt  <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (m0.req || m1.req) begin
                  r_grant <= w_pick;
                  r_last  <= w_pick;
                  r_state <= ST_REQ;
               end
            end
            ST_REQ: begin
               // A master withdrawing its request before ack abandons the
               // transaction silently.
               if (!w_g_req) begin
                  r_state <= ST_IDLE;
               end else if (bus.ack) begin
                  if (w_g_we) begin
                     r_state <= ST_IDLE;
                  end else begin
                     r_state <= ST_WAIT;
                     r_tcnt  <= '0;
                  end
               end
            end
            ST_WAIT: begin
               if (bus.resp || w_tmo_hit) begin
                  r_state <= ST_IDLE;
               end else begin
                  r_tcnt <= r_tcnt + 1'b1;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   // Bus side: only the granted master's request is visible, and only in REQ.
   assign bus.req   = w_in_req & w_g_req;
   assign bus.we    = w_in_req & w_g_we;
   assign bus.addr  = w_in_req ? w_g_addr  : 32'd0;
   assign bus.be    = w_in_req ? w_g_be    : 4'd0;
   assign bus.wdata = w_in_req ? w_g_wdata : 32'd0;

   // Handshake pulses are suppressed while reset is held so an aborted
   // transaction never completes.
   assign w_ack     = w_in_req & w_g_req & bus.ack & ~rst_i;
   assign w_timeout = w_in_wait & w_tmo_hit & ~bus.resp & ~rst_i;
   assign w_resp    = w_in_wait & ~rst_i & (bus.resp | w_tmo_hit);

   // A real response in the timeout cycle takes priority over the synthetic one.
   always_comb begin
      w_rdata = 32'd0;
      if (w_resp) begin
         w_rdata = bus.resp ? bus.rdata : TIMEOUT_RDATA;
      end
   end

   assign m0.ack    = w_ack  & ~r_grant;
   assign m1.ack    = w_ack  &  r_grant;
   assign m0.resp   = w_resp & ~r_grant;
   assign m1.resp   = w_resp &  r_grant;
   assign m0.rdata  = r_grant ? 32'd0 : w_rdata;
   assign m1.rdata  = r_grant ? w_rdata : 32'd0;
   assign timeout_o = w_timeout;

endmodule

// File: tb/tb_udm_bus_arbiter.sv
// tb/tb_udm_bus_arbiter.sv - scoreboard bench for udm_bus_arbiter
module tb_udm_bus_arbiter;

   localparam int TMO = 16;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        we;
      logic [3:0]  be;
   } ack_t;

   typedef struct {
      logic [31:0] rdata;
      logic        to;
   } resp_t;

   logic clk;
   logic rst;
   logic timeout;

   udm_bus_arbiter_if m0_if ();
   udm_bus_arbiter_if m1_if ();
   udm_bus_arbiter_if bus_if ();

   udm_bus_arbiter #(.RESP_TIMEOUT(TMO), .TIMEOUT_RDATA(32'hDEADBEEF)) dut (
      .clk_i     (clk),
      .rst_i     (rst),
      .m0        (m0_if),
      .m1        (m1_if),
      .bus       (bus_if),
      .timeout_o (timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc;
   always @(posedge clk) cyc <= cyc + 1;

   int n_cmp;
   int n_bad;

   ack_t  ackq0[$];
   ack_t  ackq1[$];
   resp_t respq0[$];
   resp_t respq1[$];
   int    ordq[$];

   int ack_cnt[2];
   int resp_cnt[2];
   int last_ack_cyc[2];
   int last_resp_cyc[2];
   int last_req_cyc[2];
   int breq_cycles;
   int tmo_cnt;

   // Slave model controls
   bit          ack_en;
   bit          resp_en;
   int          resp_dly;
   logic [31:0] rd_data;
   int          inj_req;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   // Slave: acks combinationally whenever enabled, returns read data after resp_dly cycles.
   initial begin
      int rd_cnt;
      int inj_seen;
      rd_cnt = 0;
      inj_seen = 0;
      bus_if.ack = 1'b0;
      bus_if.resp = 1'b0;
      bus_if.rdata = 32'hBAD00000;
      forever begin
         @(posedge clk);
         #2;
         bus_if.resp  = 1'b0;
         bus_if.rdata = 32'hBAD00000 ^ 32'(cyc);
         if (rd_cnt > 0) begin
            rd_cnt--;
            if (rd_cnt == 0) begin
               bus_if.resp  = 1'b1;
               bus_if.rdata = rd_data;
            end
         end
         if (inj_req != inj_seen) begin
            inj_seen     = inj_req;
            bus_if.resp  = 1'b1;
            bus_if.rdata = 32'h5555AAAA;
         end
         bus_if.ack = bus_if.req & ack_en;
         if (bus_if.ack && !bus_if.we && resp_en) rd_cnt = resp_dly;
      end
   end

   // Monitor: pops the scoreboard whenever the DUT acks or responds.
   task automatic mon_master(input int m, input logic ack, input logic resp, input logic [31:0] rdata);
      ack_t  a;
      resp_t r;
      int    o;
      if (ack) begin
         ack_cnt[m]++;
         last_ack_cyc[m] = cyc;
         if ((m == 0 ? ackq0.size() : ackq1.size()) == 0) begin
            check($sformatf("m%0d_ack_unexpected", m), 1, 0);
         end else begin
            a = (m == 0) ? ackq0.pop_front() : ackq1.pop_front();
            check($sformatf("m%0d_bus_addr", m), bus_if.addr, a.addr);
            check($sformatf("m%0d_bus_we", m), 32'(bus_if.we), 32'(a.we));
            check($sformatf("m%0d_bus_be", m), 32'(bus_if.be), 32'(a.be));
            if (a.we) check($sformatf("m%0d_bus_wdata", m), bus_if.wdata, a.wdata);
         end
         if (ordq.size() > 0) begin
            o = ordq.pop_front();
            check("grant_order", m, o);
         end
      end
      if (resp) begin
         resp_cnt[m]++;
         last_resp_cyc[m] = cyc;
         if ((m == 0 ? respq0.size() : respq1.size()) == 0) begin
            check($sformatf("m%0d_resp_unexpected", m), 1, 0);
         end else begin
            r = (m == 0) ? respq0.pop_front() : respq1.pop_front();
            check($sformatf("m%0d_rdata", m), rdata, r.rdata);
            check($sformatf("m%0d_timeout_flag", m), 32'(timeout), 32'(r.to));
         end
      end else if (rdata != 32'd0) begin
         check($sformatf("m%0d_rdata_idle", m), rdata, 0);
      end
   endtask

   always @(negedge clk) begin
      if (bus_if.req) breq_cycles++;
      if (timeout) tmo_cnt++;
      if (m0_if.ack && m1_if.ack) check("dual_ack", 1, 0);
      if (timeout && !(m0_if.resp || m1_if.resp)) check("timeout_without_resp", 1, 0);
      mon_master(0, m0_if.ack, m0_if.resp, m0_if.rdata);
      mon_master(1, m1_if.ack, m1_if.resp, m1_if.rdata);
   end

   task automatic set_master(input int m, input logic req, input logic we, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [3:0] be);
      if (m == 0) begin
         m0_if.req = req; m0_if.we = we; m0_if.addr = addr; m0_if.wdata = wdata; m0_if.be = be;
      end else begin
         m1_if.req = req; m1_if.we = we; m1_if.addr = addr; m1_if.wdata = wdata; m1_if.be = be;
      end
   endtask

   task automatic drop_req(input int m);
      if (m == 0) m0_if.req = 1'b0;
      else        m1_if.req = 1'b0;
   endtask

   // Issues one request, pushes its expectations, waits for the ack.
   task automatic mreq(input int m, input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] be, input bit exp_resp, input logic [31:0] exp_rdata,
                       input bit exp_to, input bit keep);
      ack_t  a;
      resp_t r;
      int    n;
      bit    got;
      a.addr = addr; a.wdata = wdata; a.we = we; a.be = be;
      if (m == 0) ackq0.push_back(a); else ackq1.push_back(a);
      if (!we && exp_resp) begin
         r.rdata = exp_rdata; r.to = exp_to;
         if (m == 0) respq0.push_back(r); else respq1.push_back(r);
      end
      @(posedge clk);
      #1;
      set_master(m, 1'b1, we, addr, wdata, be);
      last_req_cyc[m] = cyc;
      n = 0;
      got = 1'b0;
      while (!got && n < 200) begin
         @(negedge clk);
         n++;
         got = (m == 0) ? m0_if.ack : m1_if.ack;
      end
      if (!got) check($sformatf("m%0d_ack_wait", m), 0, 1);
      if (!keep) begin
         @(posedge clk);
         #1;
         drop_req(m);
      end
   endtask

   task automatic drain();
      int n;
      int pend;
      n = 0;
      pend = ackq0.size() + ackq1.size() + respq0.size() + respq1.size();
      while (pend != 0 && n < 100) begin
         @(negedge clk);
         n++;
         pend = ackq0.size() + ackq1.size() + respq0.size() + respq1.size();
      end
      check("drain_pending", pend, 0);
      repeat (2) @(negedge clk);
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      int b0;
      int a1;
      int r0;
      int r1;
      int t0;
      int n;
      n_cmp = 0;
      n_bad = 0;
      ack_en = 1'b1;
      resp_en = 1'b1;
      resp_dly = 1;
      rd_data = 32'd0;
      inj_req = 0;
      rst = 1'b1;
      set_master(0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
      set_master(1, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;

      // Reset state
      @(negedge clk);
      check("rst_bus_req", 32'(bus_if.req), 0);
      check("rst_bus_addr", bus_if.addr, 0);
      check("rst_m0_ack", 32'(m0_if.ack), 0);
      check("rst_m1_ack", 32'(m1_if.ack), 0);
      check("rst_m0_resp", 32'(m0_if.resp), 0);
      check("rst_timeout", 32'(timeout), 0);

      // Both masters requesting from reset: m0 first, then strict alternation
      do_reset();
      for (int k = 0; k < 8; k++) ordq.push_back(k % 2);
      fork
         begin
            for (int k = 0; k < 4; k++)
               mreq(0, 1'b1, 32'h1000 + 32'(k * 4), 32'hA0000000 + 32'(k), 4'hF, 1'b0, 32'd0, 1'b0, k < 3);
         end
         begin
            for (int k = 0; k < 4; k++)
               mreq(1, 1'b1, 32'h2000 + 32'(k * 4), 32'hB0000000 + 32'(k), 4'(k + 1), 1'b0, 32'd0, 1'b0, k < 3);
         end
      join
      drain();
      check("alt_order_consumed", ordq.size(), 0);

      // Single m0 write, zero-wait slave
      b0 = breq_cycles;
      a1 = ack_cnt[1];
      mreq(0, 1'b1, 32'h100, 32'hCAFE0001, 4'hF, 1'b0, 32'd0, 1'b0, 1'b0);
      drain();
      check("wr_bus_req_cycles", breq_cycles - b0, 1);
      check("wr_ack_latency", last_ack_cyc[0] - last_req_cyc[0], 1);
      check("wr_m1_ack_count", ack_cnt[1], a1);

      // m1 read, response 3 cycles after ack
      resp_dly = 3;
      rd_data = 32'h12345678;
      r0 = resp_cnt[0];
      mreq(1, 1'b0, 32'h200, 32'd0, 4'hF, 1'b1, 32'h12345678, 1'b0, 1'b0);
      drain();
      check("rd_resp_latency", last_resp_cyc[1] - last_ack_cyc[1], 3);
      check("rd_m0_resp_count", resp_cnt[0], r0);

      // m0 read, slave silent -> synthetic response after TMO wait cycles
      resp_en = 1'b0;
      t0 = tmo_cnt;
      mreq(0, 1'b0, 32'h300, 32'd0, 4'hF, 1'b1, 32'hDEADBEEF, 1'b1, 1'b0);
      drain();
      check("tmo_latency", last_resp_cyc[0] - last_ack_cyc[0], TMO);
      check("tmo_pulse_count", tmo_cnt - t0, 1);
      check("tmo_back_idle", 32'(bus_if.req), 0);

      // Real response lands in the timeout cycle: it wins, no timeout pulse
      resp_en = 1'b1;
      resp_dly = TMO;
      rd_data = 32'hA5A5C3C3;
      t0 = tmo_cnt;
      mreq(1, 1'b0, 32'h304, 32'd0, 4'h3, 1'b1, 32'hA5A5C3C3, 1'b0, 1'b0);
      drain();
      check("edge_resp_latency", last_resp_cyc[1] - last_ack_cyc[1], TMO);
      check("edge_no_timeout", tmo_cnt - t0, 0);

      // Granted m0 drops req before ack; next tie goes to m1
      ack_en = 1'b0;
      b0 = ack_cnt[0];
      @(posedge clk);
      #1;
      set_master(0, 1'b1, 1'b1, 32'h400, 32'h11112222, 4'hF);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!bus_if.req && n < 20);
      check("drop_bus_req_seen", 32'(bus_if.req), 1);
      @(posedge clk);
      #1;
      drop_req(0);
      @(negedge clk);
      check("drop_bus_req_low", 32'(bus_if.req), 0);
      @(negedge clk);
      check("drop_bus_req_low2", 32'(bus_if.req), 0);
      check("drop_no_ack", ack_cnt[0] - b0, 0);
      ack_en = 1'b1;
      ordq.push_back(1);
      ordq.push_back(0);
      fork
         mreq(0, 1'b1, 32'h500, 32'h33334444, 4'hF, 1'b0, 32'd0, 1'b0, 1'b0);
         mreq(1, 1'b1, 32'h600, 32'h55556666, 4'hC, 1'b0, 32'd0, 1'b0, 1'b0);
      join
      drain();
      check("drop_order_consumed", ordq.size(), 0);

      // Reset during WAIT_RESP, then a stray response: nothing forwarded
      resp_en = 1'b0;
      r0 = resp_cnt[0];
      r1 = resp_cnt[1];
      t0 = tmo_cnt;
      mreq(0, 1'b0, 32'h700, 32'd0, 4'hF, 1'b0, 32'd0, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      inj_req++;
      repeat (2 * TMO) @(negedge clk);
      check("rstmid_m0_resp", resp_cnt[0] - r0, 0);
      check("rstmid_m1_resp", resp_cnt[1] - r1, 0);
      check("rstmid_timeout", tmo_cnt - t0, 0);
      check("rstmid_bus_req", 32'(bus_if.req), 0);
      resp_en = 1'b1;
      mreq(1, 1'b1, 32'h800, 32'h77778888, 4'hF, 1'b0, 32'd0, 1'b0, 1'b0);
      drain();
      check("rstmid_m1_ack_latency", last_ack_cyc[1] - last_req_cyc[1], 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
